// File: rtl/shreg_pkg.sv
// shreg_pkg: shared constants and helpers for the variable-length shift-register delay line
package shreg_pkg;
  localparam int TAP_W = 32;
  function automatic logic init_bit(int d, int w);
    return ((d + w) % 2) == 0;
  endfunction
  function automatic int fill_w(int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/shreg_varlen_mc_if.sv
// shreg_varlen_mc_if: per-channel controls and tapped outputs of the delay line
interface shreg_varlen_mc_if import shreg_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] ce;
  logic [CHANNELS*WIDTH-1:0] i;
  logic [CHANNELS*TAP_W-1:0] l;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0] q_valid;
  logic [CHANNELS-1:0] l_oor;
  modport master (output ce, i, l, input q, q_valid, l_oor);
  modport slave (input ce, i, l, output q, q_valid, l_oor);
endinterface

// File: rtl/shreg_lane.sv
// shreg_lane: one channel of the delay line with fill tracking, tap mux and optional output register
module shreg_lane import shreg_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 130,
  parameter int NEG_EDGE = 1,
  parameter int RESET_TO_INIT = 0,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             ce,
  input  logic [WIDTH-1:0] i,
  input  logic [TAP_W-1:0] l,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             l_oor
);
  localparam int FW = fill_w(DEPTH);
  localparam int TW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef logic [WIDTH-1:0][DEPTH-1:0] stage_t;
  function automatic stage_t init_pat();
    stage_t p;
    for (int w = 0; w < WIDTH; w++)
      for (int d = 0; d < DEPTH; d++) p[w][d] = init_bit(d, w);
    return p;
  endfunction
  localparam stage_t INIT = init_pat();
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  // Inverting the clock gives a single-edge flop for the negedge variant
  logic ck;
  assign ck = clk ^ (NEG_EDGE != 0);
  stage_t s = INIT;
  logic [FW-1:0] fill = FULL;
  logic [TW-1:0] t;
  logic [WIDTH-1:0] q_c;
  logic q_valid_c, l_oor_c;
  always_ff @(posedge ck or posedge r)
    if (r) begin
      s <= RESET_TO_INIT != 0 ? INIT : '0;
      fill <= RESET_TO_INIT != 0 ? FULL : '0;
    end else if (ce) begin
      for (int w = 0; w < WIDTH; w++) s[w] <= (s[w] << 1) | DEPTH'(i[w]);
      fill <= fill + FW'(fill != FULL);
    end
  always_comb begin
    l_oor_c = l >= TAP_W'(DEPTH);
    t = l_oor_c ? TW'(DEPTH - 1) : l[TW-1:0];
    q_c = '0;
    for (int w = 0; w < WIDTH; w++) q_c[w] = s[w][t];
    q_valid_c = fill > FW'(t);
  end
  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH+1:0] o_r = '0;
    always_ff @(posedge ck or posedge r)
      if (r) o_r <= '0;
      else o_r <= {q_c, q_valid_c, l_oor_c};
    assign {q, q_valid, l_oor} = o_r;
  end else begin : g_comb
    assign {q, q_valid, l_oor} = {q_c, q_valid_c, l_oor_c};
  end
endmodule

// File: rtl/shreg_varlen_mc.sv
// shreg_varlen_mc: multi-channel variable-tap delay line, one shreg_lane per channel
module shreg_varlen_mc import shreg_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 130,
  parameter int CHANNELS = 2,
  parameter int NEG_EDGE = 1,
  parameter int RESET_TO_INIT = 0,
  parameter int OUT_REG = 0
) (
  input logic clk,
  input logic r,
  shreg_varlen_mc_if.slave bus
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    shreg_lane #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NEG_EDGE(NEG_EDGE),
      .RESET_TO_INIT(RESET_TO_INIT), .OUT_REG(OUT_REG)
    ) u_lane (
      .clk(clk),
      .r(r),
      .ce(bus.ce[c]),
      .i(bus.i[c*WIDTH +: WIDTH]),
      .l(bus.l[c*TAP_W +: TAP_W]),
      .q(bus.q[c*WIDTH +: WIDTH]),
      .q_valid(bus.q_valid[c]),
      .l_oor(bus.l_oor[c])
    );
  end
endmodule

// File: tb/tb_shreg_varlen_mc.sv
// tb_shreg_varlen_mc: randomized check of four configurations against a sample-history model
module tb_shreg_varlen_mc;
  localparam int NK = 4;
  localparam int DEP [NK] = '{130, 130, 16, 1};
  localparam int WID [NK] = '{1, 2, 2, 3};
  localparam int CH  [NK] = '{2, 2, 2, 3};
  localparam int RTI [NK] = '{0, 1, 1, 0};
  localparam int ORG [NK] = '{0, 0, 1, 0};

  logic clk = 1'b0;
  logic r = 1'b0;
  logic ce_m [NK][3] = '{default: '0};
  logic [2:0] i_m [NK][3] = '{default: '0};
  logic [31:0] l_m [NK][3] = '{default: '0};
  // Model: inputs since last reset (newest first), their count, and what lies beyond them
  int n [NK][3] = '{default: 0};
  bit base_init [NK][3] = '{default: 1'b1};
  logic [2:0] hist [NK][3][$];
  logic [4:0] reg_m [NK][3] = '{default: '0};
  int errors = 0;
  int checks = 0;

  shreg_varlen_mc_if #(.WIDTH(1), .CHANNELS(2)) b0 ();
  shreg_varlen_mc_if #(.WIDTH(2), .CHANNELS(2)) b1 ();
  shreg_varlen_mc_if #(.WIDTH(2), .CHANNELS(2)) b2 ();
  shreg_varlen_mc_if #(.WIDTH(3), .CHANNELS(3)) b3 ();

  assign b0.ce = {ce_m[0][1], ce_m[0][0]};
  assign b0.i  = {i_m[0][1][0], i_m[0][0][0]};
  assign b0.l  = {l_m[0][1], l_m[0][0]};
  assign b1.ce = {ce_m[1][1], ce_m[1][0]};
  assign b1.i  = {i_m[1][1][1:0], i_m[1][0][1:0]};
  assign b1.l  = {l_m[1][1], l_m[1][0]};
  assign b2.ce = {ce_m[2][1], ce_m[2][0]};
  assign b2.i  = {i_m[2][1][1:0], i_m[2][0][1:0]};
  assign b2.l  = {l_m[2][1], l_m[2][0]};
  assign b3.ce = {ce_m[3][2], ce_m[3][1], ce_m[3][0]};
  assign b3.i  = {i_m[3][2], i_m[3][1], i_m[3][0]};
  assign b3.l  = {l_m[3][2], l_m[3][1], l_m[3][0]};

  shreg_varlen_mc #(.WIDTH(1), .DEPTH(130), .CHANNELS(2), .NEG_EDGE(1), .RESET_TO_INIT(0), .OUT_REG(0))
    u0 (.clk(clk), .r(r), .bus(b0));
  shreg_varlen_mc #(.WIDTH(2), .DEPTH(130), .CHANNELS(2), .NEG_EDGE(1), .RESET_TO_INIT(1), .OUT_REG(0))
    u1 (.clk(clk), .r(r), .bus(b1));
  shreg_varlen_mc #(.WIDTH(2), .DEPTH(16), .CHANNELS(2), .NEG_EDGE(0), .RESET_TO_INIT(1), .OUT_REG(1))
    u2 (.clk(clk), .r(r), .bus(b2));
  shreg_varlen_mc #(.WIDTH(3), .DEPTH(1), .CHANNELS(3), .NEG_EDGE(1), .RESET_TO_INIT(0), .OUT_REG(0))
    u3 (.clk(clk), .r(r), .bus(b3));

  initial begin
    #20;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_out(int k, int c);
    logic [31:0] lv = l_m[k][c];
    logic o = lv >= 32'(DEP[k]);
    int t = o ? DEP[k] - 1 : int'(lv);
    int fill;
    logic [2:0] q = '0;
    if (t < n[k][c]) q = hist[k][c][t];
    else if (base_init[k][c])
      for (int w = 0; w < WID[k]; w++) q[w] = ((t - n[k][c] + w) % 2) == 0;
    fill = base_init[k][c] ? DEP[k] : (n[k][c] < DEP[k] ? n[k][c] : DEP[k]);
    return {q, fill > t, o};
  endfunction

  function automatic logic [4:0] dut_out(int k, int c);
    case (k)
      0: return {2'b0, b0.q[c], b0.q_valid[c], b0.l_oor[c]};
      1: return {1'b0, b1.q[c*2 +: 2], b1.q_valid[c], b1.l_oor[c]};
      2: return {1'b0, b2.q[c*2 +: 2], b2.q_valid[c], b2.l_oor[c]};
      default: return {b3.q[c*3 +: 3], b3.q_valid[c], b3.l_oor[c]};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < 3; c++) begin
        n[k][c] = 0;
        base_init[k][c] = RTI[k] != 0;
        hist[k][c].delete();
        reg_m[k][c] = '0;
      end
  endtask

  task automatic edge_upd(int k);
    if (r) return;
    for (int c = 0; c < CH[k]; c++) begin
      if (ORG[k] != 0) reg_m[k][c] = model_out(k, c);
      if (ce_m[k][c]) begin
        hist[k][c].push_front(i_m[k][c]);
        if (hist[k][c].size() > DEP[k]) void'(hist[k][c].pop_back());
        if (n[k][c] <= DEP[k]) n[k][c]++;
      end
    end
  endtask

  task automatic check_inst(int k, string ph);
    for (int c = 0; c < CH[k]; c++) begin
      logic [4:0] g = dut_out(k, c);
      logic [4:0] e = ORG[k] != 0 ? reg_m[k][c] : model_out(k, c);
      chk($sformatf("%s u%0d ch%0d q", ph, k, c), 32'(g[4:2]), 32'(e[4:2]));
      chk($sformatf("%s u%0d ch%0d q_valid", ph, k, c), 32'(g[1]), 32'(e[1]));
      chk($sformatf("%s u%0d ch%0d l_oor", ph, k, c), 32'(g[0]), 32'(e[0]));
    end
  endtask

  task automatic check_all(string ph);
    for (int k = 0; k < NK; k++) check_inst(k, ph);
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < CH[k]; c++) begin
        int sel = $urandom_range(0, 9);
        ce_m[k][c] = $urandom_range(0, 3) != 0;
        i_m[k][c] = 3'($urandom_range(0, (1 << WID[k]) - 1));
        l_m[k][c] = sel < 7 ? 32'($urandom_range(0, DEP[k] + 1))
                  : sel < 9 ? 32'($urandom_range(0, 4)) : 32'($urandom);
      end
  endtask

  initial begin
    l_m[0][0] = 32'd0;
    #1 check_all("pwr_l0");
    l_m[0][0] = 32'd1;
    #1 check_all("pwr_l1");
    l_m[0][0] = 32'd129;
    #1 check_all("pwr_l129");
    #19;
    for (int it = 0; it < 1500; it++) begin
      if (r) begin
        if ($urandom_range(0, 1) != 0) r = 1'b0;
      end else if (it == 200 || it == 900 || $urandom_range(0, 299) == 0) begin
        r = 1'b1;
        model_reset();
      end
      rand_inputs();
      #1 check_all("in");
      @(posedge clk);
      edge_upd(2);
      #1 check_inst(2, "pos");
      @(negedge clk);
      edge_upd(0);
      edge_upd(1);
      edge_upd(3);
      #1 check_all("neg");
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
